sized_fifo: RTL and testbench

- Synchronous single-clock FIFO of configurable width and depth with registered full/empty status flags.
- Used as a per-method message queue, e.g. a 32-bit × 8-entry request/indication buffer behind a portal demultiplexer.
- Producer and consumer gate ENQ/DEQ with FULL_N/EMPTY_N.
- Optional guarded mode flags protocol violations in simulation.

---
 rtl/sized_fifo.sv | 112 +++++++++++
 tb/tb_sized_fifo.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/sized_fifo.sv
// sized_fifo: synchronous single-clock FIFO with registered FULL_N/EMPTY_N flags.
//
// Ports:
//   CLK      clock, all state updates on the rising edge
//   RST_N    synchronous active-low reset (empties the FIFO)
//   D_IN     enqueue data
//   ENQ      enqueue strobe, honoured when FULL_N=1 (or when full and dequeuing)
//   DEQ      dequeue strobe, honoured when EMPTY_N=1
//   CLR      synchronous clear, same effect as reset
//   D_OUT    head-of-queue data, valid only while EMPTY_N=1
//   FULL_N   1 = space available
//   EMPTY_N  1 = data available
//
// Storage contents are never cleared; only pointers, count and flags reset.
module sized_fifo #(
    parameter int p1width      = 1,
    parameter int p2depth      = 2,
    parameter int p3cntr_width = 1,
    parameter int guarded      = 1
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [p1width-1:0] D_IN,
    input  logic               ENQ,
    input  logic               DEQ,
    input  logic               CLR,
    output logic [p1width-1:0] D_OUT,
    output logic               FULL_N,
    output logic               EMPTY_N
);

    localparam int CW = p3cntr_width;
    localparam logic [CW-1:0] LAST_IDX  = CW'(p2depth - 1);
    localparam logic [CW:0]   DEPTH_CNT = (CW + 1)'(p2depth);

    logic [p1width-1:0] mem [p2depth];
    logic [CW-1:0]      rd_ptr;
    logic [CW-1:0]      wr_ptr;
    logic [CW:0]        count;
    logic [CW:0]        count_nxt;
    logic               full_n_r;
    logic               empty_n_r;
    logic               do_enq;
    logic               do_deq;

    // Explicit wrap so non-power-of-2 depths never index past the array.
    function automatic logic [CW-1:0] ptr_incr(input logic [CW-1:0] p);
        return (p == LAST_IDX) ? '0 : p + 1'b1;
    endfunction

    // When full, a concurrent dequeue frees the head slot, which is exactly
    // where wr_ptr points, so the enqueue may proceed.
    always_comb begin
        do_deq    = DEQ && empty_n_r;
        do_enq    = ENQ && (full_n_r || do_deq);
        count_nxt = count;
        if (do_enq && !do_deq) begin
            count_nxt = count + 1'b1;
        end else if (!do_enq && do_deq) begin
            count_nxt = count - 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N || CLR) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            full_n_r  <= 1'b1;
            empty_n_r <= 1'b0;
        end else begin
            if (do_enq) begin
                wr_ptr <= ptr_incr(wr_ptr);
            end
            if (do_deq) begin
                rd_ptr <= ptr_incr(rd_ptr);
            end
            count     <= count_nxt;
            full_n_r  <= (count_nxt != DEPTH_CNT);
            empty_n_r <= (count_nxt != '0);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST_N && !CLR && do_enq) begin
            mem[wr_ptr] <= D_IN;
        end
    end

    assign D_OUT   = mem[rd_ptr];
    assign FULL_N  = full_n_r;
    assign EMPTY_N = empty_n_r;

`ifndef SYNTHESIS
    // Protocol violation reporting for simulation only.
    generate
        if (guarded != 0) begin : g_guard
            always @(posedge CLK) begin
                if (RST_N && !CLR) begin
                    if (ENQ && !full_n_r && !DEQ) begin
                        $display("WARNING: %m: ENQ while full, ignored");
                    end
                    if (DEQ && !empty_n_r) begin
                        $display("WARNING: %m: DEQ while empty, ignored");
                    end
                end
            end
        end
    endgenerate
`endif

endmodule

// File: tb/tb_sized_fifo.sv
// tb_sized_fifo: scoreboard bench for sized_fifo (32 bits x 8 entries).
// Stimulus pushes accepted enqueue data into exp_q; a negedge monitor pops
// and compares whenever the DUT presents a word that is being dequeued.
module tb_sized_fifo;

    localparam int W     = 32;
    localparam int DEPTH = 8;

    logic         CLK = 1'b0;
    logic         RST_N;
    logic [W-1:0] D_IN;
    logic         ENQ;
    logic         DEQ;
    logic         CLR;
    logic [W-1:0] D_OUT;
    logic         FULL_N;
    logic         EMPTY_N;

    int cmp_cnt = 0;
    int err_cnt = 0;
    int model_cnt = 0;
    bit check_flags = 1'b0;
    logic [W-1:0] exp_q[$];

    sized_fifo #(
        .p1width(W), .p2depth(DEPTH), .p3cntr_width(3), .guarded(1)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .D_IN(D_IN), .ENQ(ENQ), .DEQ(DEQ),
        .CLR(CLR), .D_OUT(D_OUT), .FULL_N(FULL_N), .EMPTY_N(EMPTY_N)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: check flags against the model, drive inputs, advance the model.
    task automatic step(input bit enq, input bit deq, input bit clr, input bit rst,
                        input logic [W-1:0] din);
        bit acc_deq, acc_enq;
        @(posedge CLK);
        #1;
        if (check_flags) begin
            chk("full_n", {31'b0, FULL_N}, {31'b0, model_cnt < DEPTH});
            chk("empty_n", {31'b0, EMPTY_N}, {31'b0, model_cnt > 0});
        end
        ENQ = enq; DEQ = deq; CLR = clr; RST_N = !rst; D_IN = din;
        acc_deq = deq && (model_cnt > 0);
        acc_enq = enq && ((model_cnt < DEPTH) || acc_deq);
        if (rst || clr) begin
            model_cnt = 0;
            exp_q.delete();
        end else begin
            if (acc_enq) exp_q.push_back(din);
            model_cnt = model_cnt + int'(acc_enq) - int'(acc_deq);
        end
    endtask

    task automatic idle();
        step(0, 0, 0, 0, '0);
    endtask

    // Monitor: inputs are stable mid-cycle, so negedge sees the handshake
    // that the next rising edge will perform.
    initial begin
        forever begin
            @(negedge CLK);
            if (RST_N === 1'b1 && CLR === 1'b0 && EMPTY_N === 1'b1) begin
                if (DEQ === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        cmp_cnt++;
                        err_cnt++;
                        $display("FAIL dout_underflow: got 0x%08h expected no data", D_OUT);
                    end else begin
                        chk("dout_deq", D_OUT, exp_q.pop_front());
                    end
                end else if (exp_q.size() > 0) begin
                    chk("dout_head", D_OUT, exp_q[0]);
                end
            end
        end
    end

    initial begin
        logic [W-1:0] ctr;
        RST_N = 1'b0; ENQ = 1'b0; DEQ = 1'b0; CLR = 1'b0; D_IN = '0;

        step(0, 0, 0, 1, '0);
        step(0, 0, 0, 1, '0);
        check_flags = 1'b1;
        step(0, 1, 0, 0, '0);           // deq while empty: ignored
        idle();

        step(1, 0, 0, 0, 32'h5);
        step(0, 1, 0, 0, '0);
        idle();

        for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 32'h10 + i);
        step(1, 0, 0, 0, 32'h18);       // enq while full: ignored
        for (int i = 0; i < 8; i++) step(0, 1, 0, 0, '0);
        idle();

        for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 32'h10 + i);
        step(1, 1, 0, 0, 32'hAA);       // full: simultaneous enq+deq
        for (int i = 0; i < 8; i++) step(0, 1, 0, 0, '0);
        idle();

        ctr = 32'h100;
        for (int i = 0; i < 20; i++) begin
            bit e, d;
            e = (model_cnt < 3);
            d = (model_cnt >= 2) || ((model_cnt >= 1) && ($urandom_range(1) == 1));
            step(e, d, 0, 0, ctr);
            if (e) ctr++;
        end
        while (model_cnt > 0) step(0, 1, 0, 0, '0);
        idle();

        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 32'h200 + i);
        step(1, 0, 1, 0, 32'h2FF);      // clear drops the concurrent enq
        idle();
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 32'h300 + i);
        step(1, 0, 0, 1, 32'h3FF);      // reset drops the concurrent enq
        idle();

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(3) != 0, $urandom_range(2) != 0,
                 $urandom_range(60) == 0, 1'b0, $urandom);
        end
        while (model_cnt > 0) step(0, 1, 0, 0, '0);
        idle();
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
